bitstream_bit_reader: RTL and testbench

//  Synthesizable bitstream front end for the VVC arithmetic decoder; replaces the sim-only byte file feeder.

---
 rtl/bitstream_bit_reader.sv | 189 ++++++++++++++++++
 tb/tb_bitstream_bit_reader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitstream_bit_reader.sv
// Byte-stream to variable-length bit reader feeding the CABAC engine.
// Bytes pass through a small FIFO into an MSB-aligned accumulator, optionally dropping emulation-prevention bytes.
module bitstream_bit_reader #(
    parameter int DEPTH     = 16,
    parameter int MAX_BITS  = 8,
    parameter int ACC_W     = 16,
    parameter int EPB_STRIP = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_clr,
    input  logic [7:0]                    i_in_data,
    input  logic                          i_in_valid,
    input  logic                          i_in_last,
    output logic                          o_in_ready,
    input  logic                          i_req,
    input  logic [$clog2(MAX_BITS+1)-1:0] i_req_bits,
    output logic                          o_req_ready,
    output logic [MAX_BITS-1:0]           o_out_bits,
    output logic                          o_out_valid,
    output logic                          o_out_eos,
    output logic [$clog2(ACC_W+1)-1:0]    o_bits_avail,
    output logic                          o_eos
);
    localparam int RB_W  = $clog2(MAX_BITS+1);
    localparam int CNT_W = $clog2(ACC_W+1);
    localparam int AW    = $clog2(DEPTH);
    localparam int FC_W  = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] REFILL_MAX = CNT_W'(ACC_W - 8);
    localparam logic [RB_W-1:0]  MAX_BITS_V = RB_W'(MAX_BITS);
    localparam logic [FC_W-1:0]  DEPTH_V    = FC_W'(DEPTH);

    typedef enum logic [1:0] {S_RUN, S_TAIL, S_DONE} state_t;

    state_t              r_state;
    logic [8:0]          r_mem [DEPTH];
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [FC_W-1:0]     r_fcnt;
    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_acc_cnt;
    logic [1:0]          r_zcnt;
    logic                r_drained;
    logic [MAX_BITS-1:0] r_out_bits;
    logic                r_out_valid;
    logic                r_out_eos;

    logic                w_full;
    logic                w_empty;
    logic                w_wr;
    logic [CNT_W-1:0]    w_bits_ext;
    logic                w_take;
    logic                w_short;
    logic [CNT_W-1:0]    w_taken;
    logic [CNT_W-1:0]    w_rem;
    logic                w_pop;
    logic [8:0]          w_pop_ent;
    logic [7:0]          w_pop_byte;
    logic                w_pop_last;
    logic                w_strip;
    logic [ACC_W-1:0]    w_load_word;
    logic [MAX_BITS-1:0] w_extract;
    logic [ACC_W-1:0]    w_acc_next;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [1:0]          w_zcnt_next;
    logic                w_drained_next;

    assign w_full     = (r_fcnt == DEPTH_V);
    assign w_empty    = (r_fcnt == '0);
    assign o_in_ready = !w_full && (r_state == S_RUN);
    assign w_wr       = i_in_valid && o_in_ready;

    // Once the last byte has left the FIFO, any request is served, short ones zero-padded.
    assign w_bits_ext  = CNT_W'(i_req_bits);
    assign o_req_ready = (i_req_bits != '0) && (r_state != S_DONE) &&
                         ((r_acc_cnt >= w_bits_ext) || r_drained);
    assign w_take      = i_req && o_req_ready;
    assign w_short     = (r_acc_cnt < w_bits_ext);
    assign w_taken     = !w_take ? '0 : (w_short ? r_acc_cnt : w_bits_ext);
    assign w_rem       = r_acc_cnt - w_taken;

    // Refill looks at what remains after this cycle's consume, so both overlap.
    assign w_pop       = !w_empty && (w_rem <= REFILL_MAX);
    assign w_pop_ent   = r_mem[r_rptr];
    assign w_pop_byte  = w_pop_ent[7:0];
    assign w_pop_last  = w_pop_ent[8];
    assign w_strip     = (EPB_STRIP != 0) && (r_zcnt == 2'd2) && (w_pop_byte == 8'h03);
    assign w_load_word = {w_pop_byte, {(ACC_W-8){1'b0}}} >> w_rem;

    // Bits below acc_cnt are always zero, so a short tail read pads itself.
    assign w_extract = r_acc[ACC_W-1 -: MAX_BITS] >> (MAX_BITS_V - i_req_bits);

    always_comb begin
        w_acc_next     = r_acc << w_taken;
        w_cnt_next     = w_rem;
        w_zcnt_next    = r_zcnt;
        w_drained_next = r_drained;
        if (w_pop) begin
            if (w_pop_last) begin
                w_drained_next = 1'b1;
            end
            if (w_strip) begin
                w_zcnt_next = 2'd0;
            end else begin
                w_acc_next  = w_acc_next | w_load_word;
                w_cnt_next  = w_rem + CNT_W'(8);
                if (w_pop_byte != 8'h00) begin
                    w_zcnt_next = 2'd0;
                end else if (r_zcnt != 2'd2) begin
                    w_zcnt_next = r_zcnt + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= {i_in_last, i_in_data};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_RUN;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_fcnt      <= '0;
            r_acc       <= '0;
            r_acc_cnt   <= '0;
            r_zcnt      <= 2'd0;
            r_drained   <= 1'b0;
            r_out_bits  <= '0;
            r_out_valid <= 1'b0;
            r_out_eos   <= 1'b0;
        end else if (i_clr) begin
            r_state     <= S_RUN;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_fcnt      <= '0;
            r_acc       <= '0;
            r_acc_cnt   <= '0;
            r_zcnt      <= 2'd0;
            r_drained   <= 1'b0;
            r_out_bits  <= '0;
            r_out_valid <= 1'b0;
            r_out_eos   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_fcnt      <= r_fcnt + FC_W'(w_wr) - FC_W'(w_pop);
            r_acc       <= w_acc_next;
            r_acc_cnt   <= w_cnt_next;
            r_zcnt      <= w_zcnt_next;
            r_drained   <= w_drained_next;
            r_out_valid <= w_take;
            r_out_eos   <= w_take && w_short;
            if (w_take) begin
                r_out_bits <= w_extract;
            end
            case (r_state)
                S_RUN: begin
                    if (w_wr && i_in_last) begin
                        r_state <= S_TAIL;
                    end
                end
                S_TAIL: begin
                    if (w_drained_next && (w_cnt_next == '0)) begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_DONE;
            endcase
        end
    end

    assign o_out_bits   = r_out_bits;
    assign o_out_valid  = r_out_valid;
    assign o_out_eos    = r_out_eos;
    assign o_bits_avail = r_acc_cnt;
    assign o_eos        = (r_state == S_DONE);

    a_req_bits_legal: assert property (@(posedge i_clk) disable iff (i_rst)
        i_req |-> (i_req_bits <= MAX_BITS_V));

endmodule

// File: tb/tb_bitstream_bit_reader.sv
// Scoreboard bench for bitstream_bit_reader: a bit-queue reference model predicts every result,
// a negedge monitor pops and compares whenever the reader presents one.
module tb_bitstream_bit_reader;
    localparam int DEPTH     = 16;
    localparam int MAX_BITS  = 8;
    localparam int ACC_W     = 16;
    localparam int EPB_STRIP = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic       req;
    logic [3:0] req_bits;
    logic       req_ready;
    logic [7:0] out_bits;
    logic       out_valid;
    logic       out_eos;
    logic [4:0] bits_avail;
    logic       eos;

    always #5 clk = ~clk;

    bitstream_bit_reader #(
        .DEPTH(DEPTH), .MAX_BITS(MAX_BITS), .ACC_W(ACC_W), .EPB_STRIP(EPB_STRIP)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_clr(clr),
        .i_in_data(in_data), .i_in_valid(in_valid), .i_in_last(in_last), .o_in_ready(in_ready),
        .i_req(req), .i_req_bits(req_bits), .o_req_ready(req_ready),
        .o_out_bits(out_bits), .o_out_valid(out_valid), .o_out_eos(out_eos),
        .o_bits_avail(bits_avail), .o_eos(eos)
    );

    typedef struct packed {
        logic [7:0] bits;
        logic       eos;
    } exp_t;

    int         n_vec = 0;
    int         n_bad = 0;
    bit         bitq[$];
    exp_t       expq[$];
    int         zrun = 0;
    bit         last_acc = 0;
    exp_t       e_mdl;
    exp_t       e_mon;
    logic [7:0] stream[$];

    function automatic void model_reset();
        bitq.delete();
        expq.delete();
        zrun     = 0;
        last_acc = 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    always @(posedge rst) model_reset();

    // Reference model: the stream is a flat queue of bits after EPB removal.
    always @(posedge clk) begin
        if (rst || clr) begin
            model_reset();
        end else begin
            if (req && req_ready) begin
                e_mdl = '0;
                for (int i = 0; i < int'(req_bits); i++) begin
                    e_mdl.bits = e_mdl.bits << 1;
                    if (bitq.size() > 0) e_mdl.bits[0] = bitq.pop_front();
                    else                 e_mdl.eos = 1'b1;
                end
                expq.push_back(e_mdl);
            end
            if (in_valid && in_ready) begin
                if (EPB_STRIP != 0 && zrun >= 2 && in_data == 8'h03) begin
                    zrun = 0;
                end else begin
                    for (int i = 7; i >= 0; i--) bitq.push_back(in_data[i]);
                    zrun = (in_data == 8'h00) ? ((zrun < 2) ? zrun + 1 : 2) : 0;
                end
                if (in_last) last_acc = 1;
            end
        end
    end

    // Monitor: each accepted request must produce exactly one result on the next cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                n_vec++;
                if (expq.size() == 0) begin
                    n_bad++;
                    $display("FAIL spurious_out: got out_valid=1 bits=%0h, required out_valid=0", out_bits);
                end else begin
                    e_mon = expq.pop_front();
                    if ({out_bits, out_eos} !== {e_mon.bits, e_mon.eos}) begin
                        n_bad++;
                        $display("FAIL out_bits: got %0h eos=%0b, required %0h eos=%0b",
                                 out_bits, out_eos, e_mon.bits, e_mon.eos);
                    end
                end
            end else if (expq.size() > 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL missing_out: got out_valid=0, required out_valid=1 bits=%0h", expq[0].bits);
                expq.delete();
            end
            if (eos) begin
                n_vec++;
                if (!(last_acc && bitq.size() == 0)) begin
                    n_bad++;
                    $display("FAIL early_eos: got eos=1 with %0d bits left, required eos=0", bitq.size());
                end
            end
        end
    end

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic push_stream(input int max_gap);
        int t;
        for (int i = 0; i < stream.size(); i++) begin
            in_valid = 1'b0;
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
            in_data  = stream[i];
            in_last  = (i == stream.size() - 1);
            in_valid = 1'b1;
            t = 0;
            while (!in_ready && t < 3000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 3000) begin
                chk("in_ready_timeout", 0, 1);
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic issue_req(input int n);
        int t;
        req      = 1'b1;
        req_bits = 4'(n);
        #1;
        t = 0;
        while (!req_ready && t < 500) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 500) chk("req_ready_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_bits"}, out_bits, 0);
        chk({tag, "_out_eos"}, out_eos, 0);
        chk({tag, "_bits_avail"}, bits_avail, 0);
        chk({tag, "_eos"}, eos, 0);
    endtask

    initial begin
        int n_acc;
        int bubbles;
        int len;
        rst = 1'b1; clr = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
        req = 1'b0; req_bits = 4'd1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle("reset");
        @(negedge clk);

        // Two bytes, consumed as 4+4+8 bits; eos follows the last read.
        stream = '{8'hA5, 8'h3C};
        push_stream(0);
        repeat (3) @(negedge clk);
        issue_req(4); issue_req(4); issue_req(8);
        req = 1'b0;
        chk("t1_eos", eos, 1);
        chk("t1_bits_avail", bits_avail, 0);
        do_clr();

        // Emulation-prevention byte dropped.
        stream = '{8'h00, 8'h00, 8'h03, 8'h01};
        push_stream(0);
        repeat (4) @(negedge clk);
        issue_req(8); issue_req(8); issue_req(8);
        req = 1'b0;
        chk("t2_eos", eos, 1);
        do_clr();

        // Short tail read is zero-padded.
        stream = '{8'hF3};
        push_stream(0);
        repeat (2) @(negedge clk);
        issue_req(6); issue_req(4);
        req = 1'b0; req_bits = 4'd4;
        #1;
        chk("t3_eos", eos, 1);
        chk("t3_req_ready", req_ready, 0);
        do_clr();

        // Fill with no reads: accumulator plus full FIFO.
        n_acc = 0;
        in_data = 8'h55; in_valid = 1'b1;
        for (int t = 0; t < 24; t++) begin
            if (in_ready) n_acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("fill_count", n_acc, DEPTH + 2);
        chk("fill_in_ready", in_ready, 0);
        chk("fill_bits_avail", bits_avail, ACC_W);
        do_clr();

        // 1-bit reads every cycle must never stall on a continuous stream.
        in_data = 8'h96; in_valid = 1'b1; in_last = 1'b0;
        for (int t = 0; t < 50 && bits_avail < 8; t++) @(negedge clk);
        bubbles = 0;
        req = 1'b1; req_bits = 4'd1;
        for (int t = 0; t < 48; t++) begin
            #1;
            if (!req_ready) bubbles++;
            @(negedge clk);
        end
        chk("t5_bubbles", bubbles, 0);

        // clr mid-stream with a request pending.
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; req = 1'b0; in_valid = 1'b0;
        chk("clr_bits_avail", bits_avail, 0);
        chk("clr_out_valid", out_valid, 0);
        chk("clr_in_ready", in_ready, 1);

        // Asynchronous reset drops a live result immediately.
        stream = '{8'h96, 8'h5A, 8'hC3};
        push_stream(0);
        repeat (2) @(negedge clk);
        req = 1'b1; req_bits = 4'd3;
        @(posedge clk);
        #2;
        chk("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_bits_avail", bits_avail, 0);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle("post_rst");
        @(negedge clk);

        // Randomized streams rich in 00/03 with random read widths.
        for (int it = 0; it < 8; it++) begin
            stream.delete();
            len = $urandom_range(3, 40);
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 3))
                    0, 1:    stream.push_back(8'h00);
                    2:       stream.push_back(8'h03);
                    default: stream.push_back(8'($urandom));
                endcase
            end
            fork
                push_stream(2);
                begin
                    for (int t = 0; t < 3000 && !eos; t++) begin
                        req      = ($urandom_range(0, 2) != 0);
                        req_bits = 4'($urandom_range(1, MAX_BITS));
                        @(negedge clk);
                    end
                    req = 1'b0;
                end
            join
            chk("rnd_eos", eos, 1);
            chk("rnd_bits_avail", bits_avail, 0);
            chk("rnd_in_ready", in_ready, 0);
            do_clr();
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
